// File: rtl/systolic_matmul_ctrl_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the
// parametrised systolic matrix-multiply controller.
package systolic_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_DONE
   } state_t;

   // Accept edge to last MAC edge; o_valid is seen this many cycles after accept.
   function automatic int result_latency(input int n);
      return 3 * n - 2;
   endfunction

   function automatic int cw_default(input int n, input int w);
      return 2 * w + $clog2(n) + 4;
   endfunction

endpackage

// File: rtl/systolic_matmul_ctrl_if.sv
// Operand/result handshake bundle between loader, multiplier and writeback.
interface systolic_matmul_ctrl_if
   import systolic_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int W  = W_DEF,
   parameter int CW = cw_default(N, W)
);
   logic [N*N*W-1:0]  i_a;
   logic [N*N*W-1:0]  i_b;
   logic              i_accumulate;
   logic              i_valid;
   logic              o_ready;
   logic [N*N*CW-1:0] o_c;
   logic              o_valid;
   logic              i_ready;

   modport slave (
      input  i_a, i_b, i_accumulate, i_valid, i_ready,
      output o_ready, o_c, o_valid
   );

   modport master (
      output i_a, i_b, i_accumulate, i_valid, i_ready,
      input  o_ready, o_c, o_valid
   );
endinterface

// File: rtl/systolic_matmul_ctrl_pe.sv
// Output-stationary MAC cell: multiplies the streamed a/b pair into a held
// accumulator and forwards both operands one cycle later to its neighbours.
module systolic_pe #(
   parameter int W      = 8,
   parameter int CW     = 22,
   parameter int SIGNED = 0
) (
   input  logic          i_clk,
   input  logic          i_srstn,
   input  logic          enable,
   input  logic          clear,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic [W-1:0]  a_nxt,
   output logic [W-1:0]  b_nxt,
   output logic [CW-1:0] acc
);
   logic [2*W-1:0] prod;
   logic [CW-1:0]  prod_ext;

   // Low 2W bits of the extended product equal the true signed product.
   if (SIGNED != 0) begin : g_signed
      assign prod     = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      assign prod_ext = {{(CW-2*W){prod[2*W-1]}}, prod};
   end else begin : g_unsigned
      assign prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      assign prod_ext = {{(CW-2*W){1'b0}}, prod};
   end

   always_ff @(posedge i_clk) begin
      if (!i_srstn) begin
         a_nxt <= '0;
         b_nxt <= '0;
         acc   <= '0;
      end else begin
         // Pass-through drains to zero outside COMPUTE so no stale operand
         // reaches a neighbour on the first MAC edge of the next job.
         a_nxt <= enable ? a : '0;
         b_nxt <= enable ? b : '0;
         if (clear)
            acc <= '0;
         else if (enable)
            acc <= acc + prod_ext;
      end
   end
endmodule

// File: rtl/systolic_matmul_ctrl.sv
// NxN systolic matrix multiplier with valid/ready on both sides and
// accumulate mode. Operands are skewed in at accept, C stays in the PEs.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | o_ready=1, waiting for i_valid (accept edge)
//   ST_COMPUTE | skew registers shift, PEs MAC, counter 1..3N-2
//   ST_DONE    | o_valid=1, PEs hold C until i_ready
module systolic_matmul_ctrl
   import systolic_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int W      = W_DEF,
   parameter int SIGNED = 0,
   parameter int CW     = cw_default(N, W)
) (
   input  logic                  i_clk,
   input  logic                  i_srstn,
   systolic_matmul_ctrl_if.slave bus
);
   localparam int LAT  = result_latency(N);
   localparam int CNTW = $clog2(LAT + 1);
   localparam int SL   = 2 * N - 1;

   state_t          state, state_nxt;
   logic [CNTW-1:0] cnt;
   logic            accept;
   logic            pe_en;
   logic            pe_clr;

   logic [W-1:0]  row_skew [N][SL];
   logic [W-1:0]  col_skew [N][SL];
   logic [W-1:0]  a_pass   [N][N];
   logic [W-1:0]  b_pass   [N][N];
   logic [CW-1:0] acc      [N][N];

   always_ff @(posedge i_clk) begin
      if (!i_srstn)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.o_ready = 1'b0;
      bus.o_valid = 1'b0;
      accept      = 1'b0;
      pe_en       = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.o_ready = 1'b1;
            if (bus.i_valid) begin
               accept    = 1'b1;
               state_nxt = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            pe_en = 1'b1;
            if (cnt == CNTW'(LAT - 1))
               state_nxt = ST_DONE;
         end
         ST_DONE: begin
            bus.o_valid = 1'b1;
            if (bus.i_ready)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign pe_clr = accept & ~bus.i_accumulate;

   always_ff @(posedge i_clk) begin
      if (!i_srstn)
         cnt <= '0;
      else if (state == ST_COMPUTE)
         cnt <= cnt + CNTW'(1);
      else
         cnt <= '0;
   end

   // Row r holds A[r][k] in slot r+k, column c holds B[k][c] in slot c+k;
   // slot 0 feeds the grid edge and zeros are shifted in behind.
   always_ff @(posedge i_clk) begin
      if (!i_srstn) begin
         for (int r = 0; r < N; r++)
            for (int s = 0; s < SL; s++) begin
               row_skew[r][s] <= '0;
               col_skew[r][s] <= '0;
            end
      end else if (accept) begin
         for (int r = 0; r < N; r++)
            for (int s = 0; s < SL; s++) begin
               row_skew[r][s] <= '0;
               col_skew[r][s] <= '0;
            end
         for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
               row_skew[r][r+k] <= bus.i_a[(r*N+k)*W +: W];
               col_skew[r][r+k] <= bus.i_b[(k*N+r)*W +: W];
            end
      end else if (state == ST_COMPUTE) begin
         for (int r = 0; r < N; r++) begin
            for (int s = 0; s < SL - 1; s++) begin
               row_skew[r][s] <= row_skew[r][s+1];
               col_skew[r][s] <= col_skew[r][s+1];
            end
            row_skew[r][SL-1] <= '0;
            col_skew[r][SL-1] <= '0;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic [W-1:0] a_src;
         logic [W-1:0] b_src;

         if (gj == 0) begin : g_a_edge
            assign a_src = row_skew[gi][0];
         end else begin : g_a_int
            assign a_src = a_pass[gi][gj-1];
         end

         if (gi == 0) begin : g_b_edge
            assign b_src = col_skew[gj][0];
         end else begin : g_b_int
            assign b_src = b_pass[gi-1][gj];
         end

         systolic_pe #(
            .W      (W),
            .CW     (CW),
            .SIGNED (SIGNED)
         ) u_pe (
            .i_clk   (i_clk),
            .i_srstn (i_srstn),
            .enable  (pe_en),
            .clear   (pe_clr),
            .a       (a_src),
            .b       (b_src),
            .a_nxt   (a_pass[gi][gj]),
            .b_nxt   (b_pass[gi][gj]),
            .acc     (acc[gi][gj])
         );

         assign bus.o_c[(gi*N+gj)*CW +: CW] = acc[gi][gj];
      end
   end
endmodule

// File: tb/tb_systolic_matmul_ctrl.sv
// Directed bench: unsigned/signed 4x4 instances and a minimal-width 8x8
// instance exercising wrap-around in accumulate mode.
module tb_systolic_matmul_ctrl;
   localparam int CW4 = 22;
   localparam int CW8 = 11;
   localparam logic [CW4-1:0] NEG_C = CW4'(-65024);

   logic clk = 1'b0;
   logic srstn;
   int   errs   = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   systolic_matmul_ctrl_if #(.N(4), .W(8), .CW(CW4)) if4 ();
   systolic_matmul_ctrl_if #(.N(4), .W(8), .CW(CW4)) ifs ();
   systolic_matmul_ctrl_if #(.N(8), .W(4), .CW(CW8)) if8 ();

   systolic_matmul_ctrl #(.N(4), .W(8), .SIGNED(0), .CW(CW4)) u_dut (
      .i_clk(clk), .i_srstn(srstn), .bus(if4));
   systolic_matmul_ctrl #(.N(4), .W(8), .SIGNED(1), .CW(CW4)) u_dut_s (
      .i_clk(clk), .i_srstn(srstn), .bus(ifs));
   systolic_matmul_ctrl #(.N(8), .W(4), .SIGNED(0), .CW(CW8)) u_dut8 (
      .i_clk(clk), .i_srstn(srstn), .bus(if8));

   logic [127:0]     ident, bseq, all_ff, all_80, all_7f;
   logic [16*CW4-1:0] exp_c1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Launch one job on a 4x4 instance and wait for o_valid; leaves it in DONE.
   task automatic start4(input logic sgn, input logic [127:0] a, input logic [127:0] b,
                         input logic acc, output int lat);
      @(negedge clk);
      if (sgn) begin
         ifs.i_a = a; ifs.i_b = b; ifs.i_accumulate = acc; ifs.i_valid = 1'b1;
      end else begin
         if4.i_a = a; if4.i_b = b; if4.i_accumulate = acc; if4.i_valid = 1'b1;
      end
      @(posedge clk); #1;
      if4.i_valid = 1'b0;
      ifs.i_valid = 1'b0;
      lat = 0;
      while (!(sgn ? ifs.o_valid : if4.o_valid) && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish4();
      @(negedge clk);
      if4.i_ready = 1'b1;
      ifs.i_ready = 1'b1;
      @(posedge clk); #1;
      if4.i_ready = 1'b0;
      ifs.i_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int lat;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            ident[(i*4+j)*8 +: 8]    = (i == j) ? 8'd1 : 8'd0;
            bseq[(i*4+j)*8 +: 8]     = 8'(4*i + j);
            exp_c1[(i*4+j)*CW4 +: CW4] = CW4'(4*i + j);
         end
      all_ff = '1;
      all_80 = {16{8'h80}};
      all_7f = {16{8'h7f}};

      srstn = 1'b0;
      if4.i_a = '0; if4.i_b = '0; if4.i_accumulate = 1'b0; if4.i_valid = 1'b0; if4.i_ready = 1'b0;
      ifs.i_a = '0; ifs.i_b = '0; ifs.i_accumulate = 1'b0; ifs.i_valid = 1'b0; ifs.i_ready = 1'b0;
      if8.i_a = '0; if8.i_b = '0; if8.i_accumulate = 1'b0; if8.i_valid = 1'b0; if8.i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 64'(if4.o_ready), 64'd1);
      chk("rst_valid", 64'(if4.o_valid), 64'd0);
      chk("rst_c", 64'(if4.o_c == '0), 64'd1);
      chk("rst_c8", 64'(if8.o_c == '0), 64'd1);
      @(negedge clk);
      srstn = 1'b1;

      // identity x B
      start4(1'b0, ident, bseq, 1'b0, lat);
      chk("t1_lat", 64'(lat), 64'd10);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            chk($sformatf("t1_c%0d%0d", i, j), 64'(if4.o_c[(i*4+j)*CW4 +: CW4]), 64'(4*i + j));
      finish4();
      chk("t1_ready_after", 64'(if4.o_ready), 64'd1);

      // all-255, then accumulate the same job
      start4(1'b0, all_ff, all_ff, 1'b0, lat);
      for (int e = 0; e < 16; e++)
         chk($sformatf("t2_c%0d", e), 64'(if4.o_c[e*CW4 +: CW4]), 64'd260100);
      finish4();
      start4(1'b0, all_ff, all_ff, 1'b1, lat);
      for (int e = 0; e < 16; e++)
         chk($sformatf("t2_acc%0d", e), 64'(if4.o_c[e*CW4 +: CW4]), 64'd520200);
      finish4();

      // signed: -128 x 127 summed over 4
      start4(1'b1, all_80, all_7f, 1'b0, lat);
      chk("t3_lat", 64'(lat), 64'd10);
      for (int e = 0; e < 16; e++)
         chk($sformatf("t3_c%0d", e), 64'(ifs.o_c[e*CW4 +: CW4]), 64'(NEG_C));
      finish4();

      // stall in DONE with i_valid noise during COMPUTE and DONE
      @(negedge clk);
      if4.i_a = ident; if4.i_b = bseq; if4.i_accumulate = 1'b0; if4.i_valid = 1'b1;
      @(posedge clk); #1;
      if4.i_a = all_ff; if4.i_b = all_ff; if4.i_accumulate = 1'b1;
      lat = 0;
      while (!if4.o_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 3) chk("t4_busy_ready", 64'(if4.o_ready), 64'd0);
      end
      chk("t4_lat", 64'(lat), 64'd10);
      for (int t = 0; t < 20; t++) begin
         @(posedge clk); #1;
         chk($sformatf("t4_hold_v%0d", t), 64'(if4.o_valid), 64'd1);
         chk($sformatf("t4_hold_r%0d", t), 64'(if4.o_ready), 64'd0);
         chk($sformatf("t4_hold_c%0d", t), 64'(if4.o_c == exp_c1), 64'd1);
      end
      @(negedge clk);
      if4.i_valid = 1'b0;
      if4.i_ready = 1'b1;
      @(posedge clk); #1;
      if4.i_ready = 1'b0;
      chk("t4_ready_rise", 64'(if4.o_ready), 64'd1);
      chk("t4_valid_fall", 64'(if4.o_valid), 64'd0);
      chk("t4_c_kept", 64'(if4.o_c == exp_c1), 64'd1);

      // reset at counter=5, then accumulate must start from zero
      @(negedge clk);
      if4.i_a = all_ff; if4.i_b = all_ff; if4.i_accumulate = 1'b1; if4.i_valid = 1'b1;
      @(posedge clk); #1;
      if4.i_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      srstn = 1'b0;
      @(posedge clk); #1;
      chk("t5_valid", 64'(if4.o_valid), 64'd0);
      chk("t5_c", 64'(if4.o_c == '0), 64'd1);
      chk("t5_ready", 64'(if4.o_ready), 64'd1);
      @(negedge clk);
      srstn = 1'b1;
      start4(1'b0, ident, bseq, 1'b1, lat);
      chk("t5_lat", 64'(lat), 64'd10);
      chk("t5_fresh_c", 64'(if4.o_c == exp_c1), 64'd1);
      finish4();

      // 8x8, CW=11: ten all-15 jobs accumulated modulo 2^11
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if8.i_a = '1; if8.i_b = '1; if8.i_accumulate = (n != 0); if8.i_valid = 1'b1;
         @(posedge clk); #1;
         if8.i_valid = 1'b0;
         lat = 0;
         while (!if8.o_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
         end
         chk($sformatf("t6_lat%0d", n), 64'(lat), 64'd22);
         chk($sformatf("t6_c00_%0d", n), 64'(if8.o_c[0 +: CW8]), 64'(((n + 1) * 1800) % 2048));
         @(negedge clk);
         if8.i_ready = 1'b1;
         @(posedge clk); #1;
         if8.i_ready = 1'b0;
      end
      for (int e = 0; e < 64; e++)
         chk($sformatf("t6_c%0d", e), 64'(if8.o_c[e*CW8 +: CW8]), 64'd1616);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/systolic_matmul_ctrl.md
Name: systolic_matmul_ctrl

Overview:
- Parametrised successor of the fixed 4x4, 8-bit systolic multiplier top.
- Computes C = A x B for NxN matrices of W-bit operands on an NxN output-stationary PE grid.
- Adds a valid/ready handshake on both sides, signed/unsigned mode, and an accumulate mode (C += A x B).
- Sits between the operand loader and the result writeback in the matrix-engine datapath.

Parameters:
- N, default 4: matrix dimension (rows = cols = PE grid edge), 2..16.
- W, default 8: operand width in bits.
- SIGNED, default 0: 1 = two's-complement operands and results; 0 = unsigned.
- CW, default 2*W+$clog2(N)+4: result/accumulator width; the default gives 4 guard bits for accumulate mode.

Ports:
- i_clk  in  1  clock.
- i_srstn  in  1  synchronous active-low reset.
- i_a  in  N*N*W  matrix A, packed [row][col][W].
- i_b  in  N*N*W  matrix B, packed [row][col][W].
- i_accumulate  in  1  sampled at accept; 1 = add the product into the held C, 0 = clear C first.
- i_valid  in  1  operands valid.
- o_ready  out  1  block can accept operands.
- o_c  out  N*N*CW  result matrix C, packed [row][col][CW].
- o_valid  out  1  o_c valid.
- i_ready  in  1  downstream accepts o_c.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_srstn; all state is cleared on the i_clk edge while i_srstn=0.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_c=0, all PE accumulators=0, skew registers=0, cycle counter=0.
- FSM states:
  - IDLE: o_ready=1. The cycle with i_valid&o_ready is the accept edge (edge 0). Go to COMPUTE.
  - COMPUTE: o_ready=0, PE enable=1. The counter runs 1..3N-2. Go to DONE when the counter reaches 3N-2.
  - DONE: o_valid=1, PEs disabled (hold). On i_valid... no: on i_ready=1, go to IDLE.
- Accept edge actions:
  - Row skew register r is loaded with row r of A, delayed by r slots.
  - Column skew register c is loaded with column c of B, delayed by c slots.
  - If i_accumulate=0, PE accumulators are cleared. If 1, they keep the previous C.
  - Every following COMPUTE edge shifts the skew registers by one element, inserting zeros.
- Timing:
  - PE[i][j] performs its k-th MAC on edge 1+i+j+k.
  - The last MAC (PE[N-1][N-1], k=N-1) occurs on edge 3N-2.
  - o_valid is first seen high in the cycle after edge 3N-2, i.e. 3N-2 cycles after the accept edge. For N=4 this is 10, matching the legacy block.
- Output hold: o_c and o_valid stay stable while o_valid=1 and i_ready=0, for an unbounded stall.
- Back-to-back jobs: o_ready is low in DONE, so a new accept happens no earlier than the cycle after the output handshake. Minimum job period is 3N cycles.
- i_valid outside IDLE is ignored. Operands need not be held after the accept edge.
- Arithmetic:
  - Products are 2W bits, extended to CW (sign-extended if SIGNED=1, zero-extended otherwise).
  - Accumulation is modulo 2^CW. Wrap-around on overflow is the required behaviour; no saturation and no flag.
- Reset mid-operation: in any state, i_srstn=0 returns to the reset values on that edge. The in-flight job is discarded, and so is any held C used by accumulate mode.
- o_c is driven directly from the PE accumulators. It holds the final C from DONE until the next accept edge.

Decomposition:
- Package systolic_pkg:
  - default N/W constants;
  - state enum typedef (IDLE, COMPUTE, DONE);
  - function computing the result latency 3N-2;
  - function computing the default CW.
- Sub-module systolic_pe, parametrised (W, CW, SIGNED), with ports:
  - enable, clear, a/b input and registered pass-through outputs;
  - the accumulator.
- The top holds the FSM, counter, skew registers, and generate loops that instantiate the NxN grid.

Test Plan:
1. N=4, W=8, SIGNED=0; A=identity, B[i][j]=4i+j; one accept -> o_valid rises exactly 10 cycles after accept; o_c[i][j]=4i+j.
2. All-255 A and B, N=4 -> every C element = 4*255*255 = 260100. Then same operands with i_accumulate=1 -> every element = 520200.
3. SIGNED=1, A all -128, B all 127 -> every C element = -65024. Check sign extension across CW.
4. Hold i_ready=0 for 20 cycles in DONE -> o_c/o_valid stable and o_ready=0. i_valid pulses during COMPUTE and DONE are ignored; after i_ready=1, o_ready rises next cycle.
5. Assert i_srstn=0 at counter=5 of a job -> next cycle o_valid=0, o_c=0, o_ready=1. A fresh job then produces correct results with no residue from the aborted one.
6. N=8, W=4, CW minimal (2W+3=11), accumulate 10 jobs of all-15 matrices -> results wrap modulo 2^11 (10*8*225 mod 2048 = 1616). Latency = 22 cycles.
